banked_mem_unit: RTL and testbench

//  Parametrised byte-banked data memory for the MEM stage. Holds LANES byte-wide BRAM banks.

---
 rtl/banked_mem_unit_pkg.sv | 32 +++
 rtl/banked_mem_unit_bram_bank.sv | 32 +++
 rtl/banked_mem_unit.sv | 195 +++++++++++++++++++
 tb/tb_banked_mem_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_mem_unit_pkg.sv
// Shared definitions for the byte-banked data memory.
//   - Access size codes (log2 of the byte count).
//   - clog2 helper usable in parameter expressions.
//   - Big-endian lane/bank index mapping.
// No ports: package only.
package banked_mem_unit_pkg;

    // Access size codes: log2 of the number of bytes moved.
    localparam int unsigned SZ_BYTE = 0;
    localparam int unsigned SZ_HALF = 1;
    localparam int unsigned SZ_WORD = 2;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Big-endian layout: lane 0 (lowest address within a row) lives in the highest bank.
    // The mapping is its own inverse, so it converts bank->lane and lane->bank alike.
    function automatic int unsigned lane_bank_swap(input int unsigned lanes,
                                                   input int unsigned idx);
        return lanes - 1 - idx;
    endfunction

endpackage

// File: rtl/banked_mem_unit_bram_bank.sv
// One byte-wide bank of the data memory: single-port synchronous RAM.
//   clk   in   clock, all activity on the rising edge
//   we    in   write enable, writes din to addr
//   re    in   read enable, loads dout from addr; dout holds while re is low
//   addr  in   row address
//   din   in   write byte
//   dout  out  registered read byte
module banked_mem_unit_bram_bank #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout
);

    logic [7:0] mem [DEPTH];

    // No reset: memory contents and the read register survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        if (re) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/banked_mem_unit.sv
// Byte-banked data memory for the MEM stage. LANES byte-wide banks form one row per
// LANES-byte address group; any access (including unaligned and row-crossing ones) is served
// in one bank cycle by giving each bank its own row address.
//   CLOCK_50    in   clock
//   reset       in   synchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  request accepted when req_valid & req_ready
//   req_store   in   1 store, 0 load
//   req_size    in   log2(bytes) of the access
//   req_signed  in   loads: sign-extend when set
//   req_addr    in   byte address
//   req_wdata   in   store data, right-justified, big-endian
//   resp_valid  out  response present (one per accepted request)
//   resp_ready  in   response consumed when resp_valid & resp_ready
//   resp_rdata  out  load data right-justified and extended; 0 for stores and errors
//   resp_error  out  oversize access, or misaligned access when unaligned is disallowed
module banked_mem_unit
    import banked_mem_unit_pkg::*;
#(
    parameter int unsigned  LANES           = 4,
    parameter int unsigned  ADDR_W          = 18,
    parameter bit           ALLOW_UNALIGNED = 1'b1,
    localparam int unsigned LG              = clog2(LANES),
    localparam int unsigned SZ_W            = clog2(LG + 1),
    localparam int unsigned DATA_W          = 8 * LANES
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [SZ_W-1:0]   req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error
);

    localparam int unsigned ROW_W   = ADDR_W - LG;
    localparam int unsigned DEPTH   = 2 ** ROW_W;
    localparam int unsigned BYTES_W = LG + 1;

    // ---------------------------------------------------------------- request decode
    logic               accept;
    logic [LG-1:0]      req_r;
    logic [ROW_W-1:0]   req_row;
    logic [ROW_W-1:0]   req_row_inc;
    logic [BYTES_W-1:0] req_bytes;
    logic [LG-1:0]      align_mask;
    logic               req_err;

    logic               resp_valid_q, resp_valid_d;
    logic               resp_error_q, resp_error_d;
    logic               load_q, load_d;
    logic               signed_q, signed_d;
    logic [LG-1:0]      r_q, r_d;
    logic [SZ_W-1:0]    size_q, size_d;

    assign req_ready   = ~reset & (~resp_valid_q | resp_ready);
    assign accept      = req_valid & req_ready;

    assign req_r       = req_addr[LG-1:0];
    assign req_row     = req_addr[ADDR_W-1:LG];
    // Natural wrap of the row counter carries a top-of-memory crossing back to row 0.
    assign req_row_inc = req_row + ROW_W'(1);
    assign req_bytes   = BYTES_W'(1) << req_size;

    always_comb begin
        align_mask = '0;
        for (int unsigned k = 0; k < LG; k++) begin
            if (k < 32'(req_size)) begin
                align_mask[k] = 1'b1;
            end
        end
    end

    assign req_err = (32'(req_size) > LG) | (!ALLOW_UNALIGNED & (|(req_r & align_mask)));

    // ---------------------------------------------------------------- bank control
    logic [LANES-1:0]       bank_we;
    logic [LANES-1:0]       bank_re;
    logic [LANES*ROW_W-1:0] bank_addr;
    logic [DATA_W-1:0]      bank_din;
    logic [DATA_W-1:0]      bank_dout;
    logic [LG-1:0]          wr_lane;
    logic [LG-1:0]          wr_pos;

    // For each bank: its lane, the byte position of that lane within the access (lanes
    // below the start offset belong to the next row), and the store byte it would take.
    always_comb begin
        wr_lane   = '0;
        wr_pos    = '0;
        bank_we   = '0;
        bank_re   = '0;
        bank_addr = '0;
        bank_din  = '0;
        for (int unsigned b = 0; b < LANES; b++) begin
            wr_lane = LG'(lane_bank_swap(LANES, b));
            wr_pos  = wr_lane - req_r;
            bank_addr[ROW_W*b +: ROW_W] = (wr_lane < req_r) ? req_row_inc : req_row;
            bank_din[8*b +: 8] =
                8'(req_wdata >> (8 * (int'(req_bytes) - 1 - int'(wr_pos))));
            bank_we[b] = accept & req_store & ~req_err & (BYTES_W'(wr_pos) < req_bytes);
            bank_re[b] = accept & ~req_store & ~req_err;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_bank
        banked_mem_unit_bram_bank #(
            .DEPTH  (DEPTH),
            .ADDR_W (ROW_W)
        ) u_bank (
            .clk  (CLOCK_50),
            .we   (bank_we[g]),
            .re   (bank_re[g]),
            .addr (bank_addr[ROW_W*g +: ROW_W]),
            .din  (bank_din[8*g +: 8]),
            .dout (bank_dout[8*g +: 8])
        );
    end

    // ---------------------------------------------------------------- response register
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_error_d = resp_error_q;
        load_d       = load_q;
        signed_d     = signed_q;
        r_d          = r_q;
        size_d       = size_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_error_d = req_err;
            load_d       = ~req_store & ~req_err;
            signed_d     = req_signed;
            r_d          = req_r;
            size_d       = req_size;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            load_q       <= 1'b0;
            signed_q     <= 1'b0;
            r_q          <= '0;
            size_q       <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            load_q       <= load_d;
            signed_q     <= signed_d;
            r_q          <= r_d;
            size_q       <= size_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;

    // ---------------------------------------------------------------- load formatting
    logic [DATA_W-1:0] rd_ordered;
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] rd_keep;
    logic [LG-1:0]     rd_lane;
    int unsigned       rd_shift;

    // Rotate bank outputs so the first accessed byte sits in the top byte, then shift the
    // N wanted bytes down. Bank outputs are held during a stall, so this stays stable too.
    always_comb begin
        rd_ordered = '0;
        rd_lane    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            rd_lane = r_q + LG'(i);
            rd_ordered[8*(LANES-1-i) +: 8] =
                bank_dout[8*lane_bank_swap(LANES, 32'(rd_lane)) +: 8];
        end
        rd_shift   = 8 * (LANES - (32'd1 << size_q));
        rd_shifted = rd_ordered >> rd_shift;
        rd_keep    = {DATA_W{1'b1}} >> rd_shift;
        resp_rdata = '0;
        if (load_q) begin
            resp_rdata = rd_shifted;
            if (signed_q && rd_ordered[DATA_W-1]) begin
                resp_rdata = rd_shifted | ~rd_keep;
            end
        end
    end

endmodule

// File: tb/tb_banked_mem_unit.sv
module tb_banked_mem_unit;
    import banked_mem_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_store, req_signed;
    logic [1:0]  req_size;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata;

    logic        a_req_valid, a_req_ready, a_req_store, a_req_signed;
    logic [1:0]  a_req_size;
    logic [17:0] a_req_addr;
    logic [31:0] a_req_wdata;
    logic        a_resp_valid, a_resp_ready, a_resp_error;
    logic [31:0] a_resp_rdata;

    int vectors = 0;
    int miscompares = 0;

    banked_mem_unit #(
        .LANES           (4),
        .ADDR_W          (18),
        .ALLOW_UNALIGNED (1'b1)
    ) u_dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    banked_mem_unit #(
        .LANES           (4),
        .ADDR_W          (18),
        .ALLOW_UNALIGNED (1'b0)
    ) u_dut_aligned (
        .CLOCK_50   (clk),
        .reset      (reset),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_store  (a_req_store),
        .req_size   (a_req_size),
        .req_signed (a_req_signed),
        .req_addr   (a_req_addr),
        .req_wdata  (a_req_wdata),
        .resp_valid (a_resp_valid),
        .resp_ready (a_resp_ready),
        .resp_rdata (a_resp_rdata),
        .resp_error (a_resp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ reference model
    // Flat byte-addressed memory, one outstanding response.
    logic [7:0]  mem [int unsigned];
    bit          pend = 1'b0;
    logic [31:0] exp_data = '0;
    bit          exp_err = 1'b0;
    logic [31:0] got_q [$];

    function automatic logic [7:0] mem_rd(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    task automatic model_step();
        int unsigned n;
        int unsigned a;
        logic [63:0] v;
        bit          acc;
        if (reset) begin
            pend = 1'b0;
            return;
        end
        acc = req_valid && (!pend || resp_ready);
        if (pend && resp_ready) pend = 1'b0;
        if (!acc) return;
        pend = 1'b1;
        n = 1 << req_size;
        exp_data = '0;
        exp_err  = (req_size > 2'd2);
        if (exp_err) return;
        if (req_store) begin
            for (int i = 0; i < int'(n); i++) begin
                a = (int'(req_addr) + i) & 32'h3FFFF;
                mem[a] = 8'(req_wdata >> (8 * (int'(n) - 1 - i)));
            end
        end else begin
            v = '0;
            for (int i = 0; i < int'(n); i++) begin
                a = (int'(req_addr) + i) & 32'h3FFFF;
                v = (v << 8) | 64'(mem_rd(a));
            end
            if (req_signed && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 1);
            exp_data = v[31:0];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ------------------------------------------------------------ compare process
    initial begin
        forever begin
            @(negedge clk);
            vectors++;
            if (req_ready !== (!reset && (!pend || resp_ready))) begin
                miscompares++;
                $display("FAIL req_ready got=%b exp=%b t=%0t", req_ready,
                         (!reset && (!pend || resp_ready)), $time);
            end
            vectors++;
            if (resp_valid !== pend) begin
                miscompares++;
                $display("FAIL resp_valid got=%b exp=%b t=%0t", resp_valid, pend, $time);
            end
            if (pend) begin
                vectors++;
                if (resp_rdata !== exp_data || resp_error !== exp_err) begin
                    miscompares++;
                    $display("FAIL resp_data got=%h/%b exp=%h/%b t=%0t", resp_rdata,
                             resp_error, exp_data, exp_err, $time);
                end
            end
            if (resp_valid && resp_ready) got_q.push_back(resp_rdata);
        end
    end

    // ------------------------------------------------------------ stimulus helpers
    task automatic do_req(input bit st, input int unsigned sz, input bit sg,
                          input logic [17:0] a, input logic [31:0] wd);
        int k;
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = 2'(sz);
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        vectors++;
        if (k == 20) begin
            miscompares++;
            $display("FAIL accept_timeout got=no_accept exp=accept addr=%h", a);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic load_chk(input string nm, input int unsigned sz, input bit sg,
                            input logic [17:0] a, input logic [31:0] expv);
        do_req(1'b0, sz, sg, a, 32'h0);
        @(negedge clk);
        #1;
        vectors++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== expv) begin
            miscompares++;
            $display("FAIL %s got=%h v=%b e=%b exp=%h", nm, resp_rdata, resp_valid,
                     resp_error, expv);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic err_chk(input string nm, input bit st, input int unsigned sz,
                           input logic [17:0] a, input logic [31:0] wd);
        do_req(st, sz, 1'b0, a, wd);
        @(negedge clk);
        #1;
        vectors++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL %s got=%h v=%b e=%b exp=00000000 e=1", nm, resp_rdata,
                     resp_valid, resp_error);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input string nm, input bit st, input int unsigned sz, input bit sg,
                         input logic [17:0] a, input logic [31:0] wd, input bit ee,
                         input logic [31:0] ed);
        a_req_valid  = 1'b1;
        a_req_store  = st;
        a_req_size   = 2'(sz);
        a_req_signed = sg;
        a_req_addr   = a;
        a_req_wdata  = wd;
        @(negedge clk);
        vectors++;
        if (a_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_ready got=%b exp=1", nm, a_req_ready);
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (a_resp_valid !== 1'b1 || a_resp_error !== ee || a_resp_rdata !== ed) begin
            miscompares++;
            $display("FAIL %s got=%h v=%b e=%b exp=%h e=%b", nm, a_resp_rdata, a_resp_valid,
                     a_resp_error, ed, ee);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ directed sequence
    initial begin
        logic [31:0] held;
        held         = '0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_size     = '0;
        req_signed   = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b1;
        a_req_valid  = 1'b0;
        a_req_store  = 1'b0;
        a_req_size   = '0;
        a_req_signed = 1'b0;
        a_req_addr   = '0;
        a_req_wdata  = '0;
        a_resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Aligned word
        do_req(1'b1, SZ_WORD, 1'b0, 18'h100, 32'hDEADBEEF);
        load_chk("word_aligned", SZ_WORD, 1'b0, 18'h100, 32'hDEADBEEF);
        load_chk("byte_101_u", SZ_BYTE, 1'b0, 18'h101, 32'h000000AD);
        load_chk("byte_100_s", SZ_BYTE, 1'b1, 18'h100, 32'hFFFFFFDE);

        // Row crossing
        do_req(1'b1, SZ_WORD, 1'b0, 18'h103, 32'h11223344);
        load_chk("byte_103_s", SZ_BYTE, 1'b1, 18'h103, 32'h00000011);
        load_chk("half_104", SZ_HALF, 1'b0, 18'h104, 32'h00002233);
        load_chk("word_103", SZ_WORD, 1'b0, 18'h103, 32'h11223344);
        load_chk("word_100_mix", SZ_WORD, 1'b0, 18'h100, 32'hDEADBE11);

        // Extension; bytes 0 and 1 must survive the half store
        do_req(1'b1, SZ_WORD, 1'b0, 18'h0, 32'h01020304);
        do_req(1'b1, SZ_HALF, 1'b0, 18'h2, 32'h000080F0);
        load_chk("half_2_s", SZ_HALF, 1'b1, 18'h2, 32'hFFFF80F0);
        load_chk("half_2_u", SZ_HALF, 1'b0, 18'h2, 32'h000080F0);
        load_chk("byte_0_kept", SZ_BYTE, 1'b0, 18'h0, 32'h00000001);
        load_chk("byte_1_kept", SZ_BYTE, 1'b0, 18'h1, 32'h00000002);

        // Top-of-memory wrap
        do_req(1'b1, SZ_WORD, 1'b0, 18'h3FFFE, 32'hA1B2C3D4);
        load_chk("wrap_byte_0", SZ_BYTE, 1'b0, 18'h0, 32'h000000C3);
        load_chk("wrap_byte_1", SZ_BYTE, 1'b0, 18'h1, 32'h000000D4);
        load_chk("wrap_word", SZ_WORD, 1'b0, 18'h3FFFE, 32'hA1B2C3D4);
        load_chk("wrap_half_s", SZ_HALF, 1'b1, 18'h3FFFF, 32'hFFFFB2C3);

        // Back-pressure
        resp_ready = 1'b0;
        got_q.delete();
        do_req(1'b0, SZ_WORD, 1'b0, 18'h100, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_ready got=%b exp=0", req_ready);
            end
            if (k == 0) begin
                held = resp_rdata;
                vectors++;
                if (held !== 32'hDEADBE11) begin
                    miscompares++;
                    $display("FAIL stall_first got=%h exp=deadbe11", held);
                end
            end else begin
                vectors++;
                if (resp_rdata !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold got=%h exp=%h", resp_rdata, held);
                end
            end
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        do_req(1'b0, SZ_WORD, 1'b0, 18'h103, 32'h0);
        do_req(1'b0, SZ_BYTE, 1'b0, 18'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (got_q.size() != 3) begin
            miscompares++;
            $display("FAIL bp_count got=%0d exp=3", got_q.size());
        end else begin
            vectors++;
            if (got_q[0] !== 32'hDEADBE11 || got_q[1] !== 32'h11223344 ||
                got_q[2] !== 32'h000000C3) begin
                miscompares++;
                $display("FAIL bp_order got=%h,%h,%h exp=deadbe11,11223344,000000c3",
                         got_q[0], got_q[1], got_q[2]);
            end
        end

        // Errors
        err_chk("size3_load", 1'b0, 3, 18'h100, 32'h0);
        err_chk("size3_store", 1'b1, 3, 18'h100, 32'hFFFFFFFF);
        load_chk("after_err", SZ_WORD, 1'b0, 18'h100, 32'hDEADBE11);
        a_req("ua_half_err", 1'b0, SZ_HALF, 1'b0, 18'h1, 32'h0, 1'b1, 32'h0);
        a_req("ua_store_ok", 1'b1, SZ_HALF, 1'b0, 18'h2, 32'h00001234, 1'b0, 32'h0);
        a_req("ua_load_ok", 1'b0, SZ_HALF, 1'b0, 18'h2, 32'h0, 1'b0, 32'h00001234);
        a_req("ua_word_err", 1'b0, SZ_WORD, 1'b0, 18'h2, 32'h0, 1'b1, 32'h0);
        a_req("ua_store_err", 1'b1, SZ_WORD, 1'b0, 18'h2, 32'hFFFFFFFF, 1'b1, 32'h0);
        a_req("ua_load_after", 1'b0, SZ_HALF, 1'b1, 18'h2, 32'h0, 1'b0, 32'h00001234);

        // Reset during a stalled response; a store presented under reset is ignored
        resp_ready = 1'b0;
        do_req(1'b0, SZ_WORD, 1'b0, 18'h100, 32'h0);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_store = 1'b1;
        req_size  = 2'(SZ_WORD);
        req_addr  = 18'h100;
        req_wdata = 32'h55555555;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready got=%b exp=0", req_ready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_drop got=%b exp=0", resp_valid);
        end
        @(posedge clk);
        #1;
        reset      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        load_chk("reset_no_write", SZ_WORD, 1'b0, 18'h100, 32'hDEADBE11);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
